memory_arbiter: RTL and testbench

//  Shares the single line-wide main memory between the instruction cache (port I)
//  and the data cache (port D). Arbitrates, holds the winning request stable for

---
 rtl/memory_arbiter.sv | 135 +++++++++++++
 tb/tb_memory_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one line-wide main memory between the instruction cache (port I,
//   read only) and the data cache (port D, line fill or write-back). A request
//   seen in IDLE is latched and held on the memory bus for LATENCY cycles
//   (WAIT), then the winner gets a one-cycle ack (ACK) carrying the read line.
//   The memory read path is combinational from mem_addr.
//
//   Parameters: WIDTH (line bits), ADDR (byte address bits), LATENCY (>=1).
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     i_req/i_addr -> i_ack/i_rdata I-cache read port
//     d_req/d_write/d_addr/d_wdata  D-cache request
//       -> d_ack/d_rdata
//     mem_addr/mem_wdata/mem_read/mem_write -> memory, mem_rdata <- memory
//
//   Configuration macro ARB_ROUND_ROBIN_EN:
//     defined   - on a tie the port not granted last wins (pointer favours I
//                 after reset)
//     undefined - fixed priority, D beats I on a tie
module memory_arbiter #(
  parameter int WIDTH   = 128,
  parameter int ADDR    = 32,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [ADDR-1:0]  i_addr,
  output logic             i_ack,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_write,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             grant_d_reg;  // 1 = D owns the current access
  logic             write_reg;    // current access is a D write-back
  logic [WIDTH-1:0] rdata_reg;    // read line returned with the ack
  logic             win_d;        // arbitration result for this IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_d_reg;  // 1 = a tie goes to D

  always_comb begin
    win_d = d_req && (!i_req || rr_d_reg);
  end
`else
  // Data misses stall the MEM stage, so D wins whenever it asks.
  always_comb begin
    win_d = d_req;
  end
`endif

  assign i_rdata = rdata_reg;
  assign d_rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      grant_d_reg <= 1'b0;
      write_reg   <= 1'b0;
      rdata_reg   <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_d_reg    <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d_reg <= win_d;
            write_reg   <= win_d && d_write;
            mem_addr    <= win_d ? d_addr : i_addr;
            if (win_d) begin
              mem_wdata <= d_wdata;
            end
            cnt_reg     <= CW'(LATENCY - 1);
            mem_read    <= !(win_d && d_write);
            // With a single-cycle access the first WAIT cycle is also the last.
            mem_write   <= (LATENCY == 1) && win_d && d_write;
            state_reg   <= WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            rr_d_reg    <= !win_d;
`endif
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            if (!write_reg) begin
              rdata_reg <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_ack     <= !grant_d_reg;
            d_ack     <= grant_d_reg;
            state_reg <= ACK;
          end else begin
            cnt_reg   <= cnt_reg - CW'(1);
            // Write strobe only in the final WAIT cycle: one memory write.
            mem_write <= write_reg && (cnt_reg == CW'(1));
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed bench for memory_arbiter (LATENCY=4, WIDTH=128). Two requester
//   agents drive the I and D ports from posted request tables, a small line
//   memory answers the memory bus, and a transaction-level model predicts the
//   bus and ack activity that every cycle is compared against. Directed tests
//   add hand-computed latency/data expectations.
module tb_memory_arbiter;

  localparam int LAT = 4;

  logic         clk;
  logic         reset;
  logic         i_req, d_req, d_write;
  logic [31:0]  i_addr, d_addr;
  logic [127:0] d_wdata;
  logic         i_ack, d_ack;
  logic [127:0] i_rdata, d_rdata;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_read, mem_write;

  memory_arbiter #(.WIDTH(128), .ADDR(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory --------------------------------------------------
  function automatic logic [127:0] line_init(input int i);
    logic [7:0] b;
    b = 8'(i) + 8'h30;
    return {{15{b}}, 8'hAA};
  endfunction

  logic [127:0] mem [16];
  logic         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 16; k++) mem[k] <= line_init(k);
      mem_loaded <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[7:4]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:4]];

  // ---------------- requester agents -----------------------------------------
  int           i_posted = 0, i_served = 0, d_posted = 0, d_served = 0;
  logic         i_active, d_active;
  logic         d_garble = 1'b0;
  logic [31:0]  iq_addr [16];
  logic [31:0]  dq_addr [16];
  logic         dq_write [16];
  logic [127:0] dq_wdata [16];
  int           i_iss [16], i_ackc [16], d_iss [16], d_ackc [16];
  logic [127:0] i_rd [16], d_rd [16];

  task automatic post_i(input logic [31:0] a);
    iq_addr[i_posted] = a;
    i_posted++;
  endtask

  task automatic post_d(input logic w, input logic [31:0] a, input logic [127:0] wd);
    dq_write[d_posted] = w;
    dq_addr[d_posted]  = a;
    dq_wdata[d_posted] = wd;
    d_posted++;
  endtask

  initial begin
    logic ack_seen, rst_seen;
    int   ack_cyc;
    logic [127:0] rd;
    i_req = 1'b0; i_addr = '0; i_active = 1'b0;
    forever begin
      @(negedge clk);
      ack_seen = i_ack; rst_seen = reset; ack_cyc = cyc; rd = i_rdata;
      @(posedge clk); #1;
      if (rst_seen) begin
        i_req = 1'b0; i_active = 1'b0; i_served = i_posted;
      end else begin
        if (ack_seen && i_active) begin
          i_ackc[i_served] = ack_cyc; i_rd[i_served] = rd;
          i_active = 1'b0; i_req = 1'b0; i_served++;
        end
        if (!i_active && i_served < i_posted) begin
          i_active = 1'b1; i_req = 1'b1; i_addr = iq_addr[i_served];
          i_iss[i_served] = cyc;
        end
      end
    end
  end

  initial begin
    logic ack_seen, rst_seen;
    int   ack_cyc;
    logic [127:0] rd;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_active = 1'b0;
    forever begin
      @(negedge clk);
      ack_seen = d_ack; rst_seen = reset; ack_cyc = cyc; rd = d_rdata;
      @(posedge clk); #1;
      if (rst_seen) begin
        d_req = 1'b0; d_active = 1'b0; d_served = d_posted;
      end else begin
        if (ack_seen && d_active) begin
          d_ackc[d_served] = ack_cyc; d_rd[d_served] = rd;
          d_active = 1'b0; d_req = 1'b0; d_served++;
        end
        if (!d_active && d_served < d_posted) begin
          d_active = 1'b1; d_req = 1'b1;
          d_write = dq_write[d_served]; d_wdata = dq_wdata[d_served];
          d_iss[d_served] = cyc;
        end
        if (d_active) d_addr = d_garble ? 32'h30 : dq_addr[d_served];
      end
    end
  end

  // ---------------- bus monitor ----------------------------------------------
  int   rd_pulses = 0, wr_pulses = 0, last_wr_cyc = 0, i_ack_total = 0, d_ack_total = 0;
  logic [31:0] last_wr_addr = '0;
  int   ack_log [$];
  always @(negedge clk) begin
    if (mem_read) rd_pulses++;
    if (mem_write) begin
      wr_pulses++; last_wr_cyc = cyc; last_wr_addr = mem_addr;
    end
    if (i_ack) begin i_ack_total++; ack_log.push_back(0); end
    if (d_ack) begin d_ack_total++; ack_log.push_back(1); end
  end

  // ---------------- transaction model ----------------------------------------
  // One access at a time: granted at the end of cycle m_start, owns the bus
  // for cycles m_start+1..m_start+LAT, acked in m_start+LAT+1.
  logic         m_busy = 1'b0, m_port_d = 1'b0, m_write = 1'b0, m_tie_i = 1'b1;
  int           m_start = 0;
  logic [31:0]  m_addr = '0;
  logic [127:0] m_wdata = '0;
  logic [127:0] ref_mem [16];
  logic         ref_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ref_loaded) begin
      for (int k = 0; k < 16; k++) ref_mem[k] = line_init(k);
      ref_loaded = 1'b1;
    end
    if (m_busy && m_write && cyc == m_start + LAT) ref_mem[m_addr[7:4]] = m_wdata;
    if (reset) begin
      m_busy = 1'b0; m_tie_i = 1'b1;
    end else if (m_busy) begin
      if (cyc == m_start + LAT + 1) m_busy = 1'b0;
    end else if (i_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_port_d = (i_req && d_req) ? !m_tie_i : d_req;
`else
      m_port_d = d_req;
`endif
      m_tie_i = m_port_d;  // the next tie goes to the other port
      m_busy  = 1'b1;
      m_start = cyc;
      m_addr  = m_port_d ? d_addr : i_addr;
      m_write = m_port_d && d_write;
      m_wdata = d_wdata;
    end
  end

  logic chk_en = 1'b0;
  logic e_win, e_ack;
  always @(negedge clk) begin
    if (chk_en) begin
      e_win = m_busy && cyc >= m_start + 1 && cyc <= m_start + LAT;
      e_ack = m_busy && cyc == m_start + LAT + 1;
      chk("i_ack", i_ack, e_ack && !m_port_d);
      chk("d_ack", d_ack, e_ack && m_port_d);
      chk("mem_read", mem_read, e_win && !m_write);
      chk("mem_write", mem_write, e_win && m_write && cyc == m_start + LAT);
      if (e_win) chk("mem_addr", mem_addr, m_addr);
      if (e_win && m_write) chk("mem_wdata", mem_wdata, m_wdata);
      if (e_ack && !m_write && m_port_d) chk("d_rdata", d_rdata, ref_mem[m_addr[7:4]]);
      if (e_ack && !m_write && !m_port_d) chk("i_rdata", i_rdata, ref_mem[m_addr[7:4]]);
    end
  end

  // ---------------- directed tests -------------------------------------------
  task automatic wait_i(input int n);
    int t = 0;
    while (i_served < n && t < 300) begin @(negedge clk); t++; end
    chk("i_done", i_served, n);
  endtask

  task automatic wait_d(input int n);
    int t = 0;
    while (d_served < n && t < 300) begin @(negedge clk); t++; end
    chk("d_done", d_served, n);
  endtask

  initial begin
    int ki, kd, r0, w0, da0, t, lg;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_i_ack", i_ack, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_rdata", i_rdata, 128'h0);
    chk_en = 1'b1;

    // 1: I read of line 1
    ki = i_posted; r0 = rd_pulses; da0 = d_ack_total;
    post_i(32'h10);
    wait_i(ki + 1);
    chk("t1_i_latency", i_ackc[ki] - i_iss[ki], 5);
    chk("t1_i_rdata", i_rd[ki], 128'h31313131_31313131_31313131_313131AA);
    chk("t1_d_acks", d_ack_total - da0, 0);
    chk("t1_read_cycles", rd_pulses - r0, 4);

    // 2: D write-back then read back
    @(negedge clk);
    kd = d_posted; w0 = wr_pulses;
    post_d(1'b1, 32'h20, 128'hDEAD);
    wait_d(kd + 1);
    chk("t2_d_latency", d_ackc[kd] - d_iss[kd], 5);
    chk("t2_write_pulses", wr_pulses - w0, 1);
    chk("t2_write_cycle", last_wr_cyc - d_iss[kd], 4);
    @(negedge clk);
    post_d(1'b0, 32'h20, 128'h0);
    wait_d(kd + 2);
    chk("t2_readback", d_rd[kd + 1], 128'hDEAD);

    // 4: address input changes during WAIT
    @(negedge clk);
    kd = d_posted;
    post_d(1'b1, 32'h20, 128'h1234);
    repeat (3) @(negedge clk);
    d_garble = 1'b1;
    wait_d(kd + 1);
    d_garble = 1'b0;
    @(negedge clk);
    chk("t4_write_addr", last_wr_addr, 32'h20);
    chk("t4_line2", mem[2], 128'h1234);
    chk("t4_line3_untouched", mem[3], 128'h33333333_33333333_33333333_333333AA);

    // 3: simultaneous requests
    @(negedge clk);
    ki = i_posted; kd = d_posted; lg = ack_log.size();
    post_i(32'h30); post_d(1'b0, 32'h50, 128'h0);
    wait_i(ki + 1); wait_d(kd + 1);
`ifdef ARB_ROUND_ROBIN_EN
    @(negedge clk);
    post_i(32'h60); post_d(1'b0, 32'h70, 128'h0);
    wait_i(ki + 2); wait_d(kd + 2);
    @(negedge clk);
    chk("t3_rr_grant0", ack_log[lg], 0);
    chk("t3_rr_grant1", ack_log[lg + 1], 1);
    chk("t3_rr_grant2", ack_log[lg + 2], 0);
    chk("t3_rr_grant3", ack_log[lg + 3], 1);
`else
    chk("t3_d_latency", d_ackc[kd] - d_iss[kd], 5);
    chk("t3_i_latency", i_ackc[ki] - i_iss[ki], 11);
`endif

    // 5: reset in cycle 2 of a write
    @(negedge clk);
    kd = d_posted; w0 = wr_pulses; da0 = d_ack_total;
    post_d(1'b1, 32'h40, 128'h5555);
    t = 0;
    while (!(d_active && d_served == kd) && t < 50) begin @(negedge clk); t++; end
    while (cyc < d_iss[kd] + 1 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_mem_read", mem_read, 1'b0);
    chk("t5_rdata_cleared", i_rdata, 128'h0);
    repeat (6) @(negedge clk);
    chk("t5_no_write", wr_pulses - w0, 0);
    chk("t5_no_ack", d_ack_total - da0, 0);
    chk("t5_line4_untouched", mem[4], 128'h34343434_34343434_34343434_343434AA);
    ki = i_posted;
    post_i(32'h10);
    wait_i(ki + 1);
    chk("t5_i_latency", i_ackc[ki] - i_iss[ki], 5);

    // 6: D keeps re-issuing while I waits
    @(negedge clk);
    ki = i_posted; kd = d_posted;
    post_i(32'h60);
    post_d(1'b0, 32'h70, 128'h0); post_d(1'b0, 32'h80, 128'h0); post_d(1'b0, 32'h90, 128'h0);
    wait_i(ki + 1); wait_d(kd + 3);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t6_i_latency", i_ackc[ki] - i_iss[ki], 11);
`else
    chk("t6_i_latency", i_ackc[ki] - i_iss[ki], 23);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
